// File: rtl/usrt_apb_ctrl.sv
// USRT APB3 slave: one-wait-state register access, TX/RX byte FIFOs, enable/flush control, IRQ.
// APB completes 2 cycles after access phase; TX streams by valid/ready, RX push has no backpressure.
module usrt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  // full/empty come from the pre-edge count, so a push into a full FIFO is dropped
  // even when a pop happens in the same cycle
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_n && !clr && push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module usrt_apb_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic       i_Pclk,
  input  logic       i_Presetn,
  input  logic       i_Psel,
  input  logic       i_Penable,
  input  logic       i_Pwrite,
  input  logic       i_Paddr,
  input  logic [7:0] i_Pwdata,
  output logic [7:0] o_Prdata,
  output logic       o_Pready,
  output logic       o_Pslverr,
  output logic [7:0] o_TxData,
  output logic       o_TxValid,
  input  logic       i_TxReady,
  input  logic [7:0] i_RxData,
  input  logic       i_RxValid,
  output logic       o_Irq
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_HOLD} state_t;

  state_t     state;
  logic       tx_en;
  logic       rx_en;
  logic       rx_ovf;
  logic       tx_full;
  logic       tx_empty;
  logic       rx_full;
  logic       rx_empty;
  logic [7:0] rx_head;
  logic [7:0] status;
  logic       commit;
  logic       tx_push;
  logic       tx_pop;
  logic       rx_pop;
  logic       rx_push;
  logic       flush;
  logic       status_rd;
  logic       ovf_evt;
  logic       access;

  // all side effects land on the single edge that leaves WAIT
  assign access    = i_Psel & i_Penable;
  assign commit    = (state == ST_WAIT);
  assign tx_push   = commit & i_Pwrite & ~i_Paddr;
  assign rx_pop    = commit & ~i_Pwrite & ~i_Paddr;
  assign flush     = commit & i_Pwrite & i_Paddr & i_Pwdata[2];
  assign status_rd = commit & ~i_Pwrite & i_Paddr;
  assign rx_push   = i_RxValid & rx_en;
  assign ovf_evt   = rx_push & rx_full;
  assign o_TxValid = tx_en & ~tx_empty;
  assign tx_pop    = o_TxValid & i_TxReady;
  assign status    = {1'b0, rx_en, tx_en, rx_ovf, rx_full, rx_empty, tx_full, tx_empty};

  usrt_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
    .clk   (i_Pclk),
    .rst_n (i_Presetn),
    .clr   (flush),
    .push  (tx_push),
    .din   (i_Pwdata),
    .pop   (tx_pop),
    .head  (o_TxData),
    .full  (tx_full),
    .empty (tx_empty)
  );

  usrt_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
    .clk   (i_Pclk),
    .rst_n (i_Presetn),
    .clr   (flush),
    .push  (rx_push),
    .din   (i_RxData),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge i_Pclk) begin
    if (!i_Presetn) begin
      state     <= ST_IDLE;
      o_Pready  <= 1'b0;
      o_Prdata  <= 8'h00;
      o_Pslverr <= 1'b0;
      tx_en     <= 1'b0;
      rx_en     <= 1'b0;
      rx_ovf    <= 1'b0;
      o_Irq     <= 1'b0;
    end else begin
      o_Irq <= (rx_en & ~rx_empty) | rx_ovf;

      // flush beats an overflow, which beats the clear-on-status-read
      if (flush)          rx_ovf <= 1'b0;
      else if (ovf_evt)   rx_ovf <= 1'b1;
      else if (status_rd) rx_ovf <= 1'b0;

      case (state)
        ST_IDLE: begin
          o_Pready <= 1'b0;
          if (access) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_Pwrite) begin
            o_Prdata  <= 8'h00;
            o_Pslverr <= ~i_Paddr & tx_full;
            if (i_Paddr) begin
              tx_en <= i_Pwdata[0];
              rx_en <= i_Pwdata[1];
            end
          end else if (!i_Paddr) begin
            o_Prdata  <= rx_empty ? 8'h00 : rx_head;
            o_Pslverr <= rx_empty;
          end else begin
            o_Prdata  <= status;
            o_Pslverr <= 1'b0;
          end
          if (i_Psel) begin
            state    <= ST_RESP;
            o_Pready <= 1'b1;
          end else begin
            state    <= ST_IDLE;
            o_Pready <= 1'b0;
          end
        end
        ST_RESP: begin
          if (access) begin
            state <= ST_HOLD;
          end else begin
            state    <= ST_IDLE;
            o_Pready <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!access) begin
            state    <= ST_IDLE;
            o_Pready <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          o_Pready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_usrt_apb_ctrl.sv
// Bench for usrt_apb_ctrl: directed scenarios plus random APB/RX/TX traffic
// checked against a queue-based model of the FIFOs and control bits.
module tb_usrt_apb_ctrl;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic       clk = 1'b0;
  logic       i_Presetn;
  logic       i_Psel;
  logic       i_Penable;
  logic       i_Pwrite;
  logic       i_Paddr;
  logic [7:0] i_Pwdata;
  logic [7:0] o_Prdata;
  logic       o_Pready;
  logic       o_Pslverr;
  logic [7:0] o_TxData;
  logic       o_TxValid;
  logic       i_TxReady;
  logic [7:0] i_RxData;
  logic       i_RxValid;
  logic       o_Irq;

  always #5 clk = ~clk;

  usrt_apb_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .i_Pclk    (clk),
    .i_Presetn (i_Presetn),
    .i_Psel    (i_Psel),
    .i_Penable (i_Penable),
    .i_Pwrite  (i_Pwrite),
    .i_Paddr   (i_Paddr),
    .i_Pwdata  (i_Pwdata),
    .o_Prdata  (o_Prdata),
    .o_Pready  (o_Pready),
    .o_Pslverr (o_Pslverr),
    .o_TxData  (o_TxData),
    .o_TxValid (o_TxValid),
    .i_TxReady (i_TxReady),
    .i_RxData  (i_RxData),
    .i_RxValid (i_RxValid),
    .o_Irq     (o_Irq)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_tx_en;
  logic       m_rx_en;
  logic       m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_tx_en = 1'b0;
    m_rx_en = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // effect of one committed APB transfer, optionally with an RX strobe on the commit edge
  task automatic model_xfer(input logic wr, input logic addr, input logic [7:0] wd,
                            input logic inj, input logic [7:0] rb,
                            output logic [7:0] erd, output logic eerr);
    logic rx_full;
    logic rx_acc;
    erd  = 8'h00;
    eerr = 1'b0;
    if (wr) begin
      if (!addr && tx_q.size() == TXD) eerr = 1'b1;
    end else if (!addr) begin
      if (rx_q.size() == 0) eerr = 1'b1;
      else erd = rx_q[0];
    end else begin
      erd = {1'b0, m_rx_en, m_tx_en, m_ovf, rx_q.size() == RXD, rx_q.size() == 0,
             tx_q.size() == TXD, tx_q.size() == 0};
    end
    rx_full = (rx_q.size() == RXD);
    rx_acc  = inj && m_rx_en;
    if (wr && addr && wd[2]) begin
      tx_q.delete();
      rx_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (!wr && !addr && rx_q.size() > 0) void'(rx_q.pop_front());
      if (rx_acc && !rx_full) rx_q.push_back(rb);
      if (rx_acc && rx_full) m_ovf = 1'b1;
      else if (!wr && addr) m_ovf = 1'b0;
      if (wr && !addr && tx_q.size() < TXD) tx_q.push_back(wd);
    end
    if (wr && addr) begin
      m_tx_en = wd[0];
      m_rx_en = wd[1];
    end
  endtask

  task automatic xfer(input logic wr, input logic addr, input logic [7:0] wd,
                      input logic inj, input logic [7:0] rb,
                      output logic [7:0] rd, output logic err);
    logic [7:0] erd;
    logic       eerr;
    int         n;
    @(negedge clk);
    i_Psel = 1'b1; i_Penable = 1'b0; i_Pwrite = wr; i_Paddr = addr; i_Pwdata = wd;
    @(negedge clk);
    i_Penable = 1'b1;
    @(negedge clk);
    if (inj) begin
      i_RxValid = 1'b1;
      i_RxData  = rb;
    end
    chk("wait_pready_low", o_Pready, 0);
    n = 0;
    do begin
      @(negedge clk);
      i_RxValid = 1'b0;
      n++;
    end while (!o_Pready && n < 8);
    chk("wait_states", n, 1);
    rd  = o_Prdata;
    err = o_Pslverr;
    i_Psel = 1'b0; i_Penable = 1'b0;
    model_xfer(wr, addr, wd, inj, rb, erd, eerr);
    if (wr) begin
      chk("wr_slverr", err, eerr);
    end else begin
      if (addr) chk("status_rd", rd, erd);
      else      chk("data_rd", rd, erd);
      chk("rd_slverr", err, eerr);
    end
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    i_RxValid = 1'b1;
    i_RxData  = b;
    @(negedge clk);
    i_RxValid = 1'b0;
    if (m_rx_en) begin
      if (rx_q.size() == RXD) m_ovf = 1'b1;
      else rx_q.push_back(b);
    end
  endtask

  task automatic drain();
    logic exp_v;
    @(negedge clk);
    exp_v = m_tx_en && tx_q.size() > 0;
    chk("drain_valid", o_TxValid, exp_v);
    if (exp_v) chk("drain_data", o_TxData, tx_q[0]);
    i_TxReady = 1'b1;
    @(negedge clk);
    i_TxReady = 1'b0;
    if (exp_v) void'(tx_q.pop_front());
  endtask

  task automatic check_outs();
    logic exp_v;
    @(negedge clk);
    exp_v = m_tx_en && tx_q.size() > 0;
    chk("tx_valid", o_TxValid, exp_v);
    if (exp_v) chk("tx_data", o_TxData, tx_q[0]);
    chk("irq", o_Irq, (m_rx_en && rx_q.size() > 0) || m_ovf);
  endtask

  logic [7:0] rd;
  logic       err;
  logic [7:0] erd;
  logic       eerr;

  initial begin
    i_Presetn = 1'b0; i_Psel = 1'b0; i_Penable = 1'b0; i_Pwrite = 1'b0; i_Paddr = 1'b0;
    i_Pwdata = 8'h00; i_TxReady = 1'b0; i_RxData = 8'h00; i_RxValid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    i_Presetn = 1'b1;
    @(negedge clk);
    chk("rst_prdata", o_Prdata, 8'h00);
    chk("rst_pready", o_Pready, 0);
    chk("rst_pslverr", o_Pslverr, 0);
    chk("rst_txvalid", o_TxValid, 0);
    chk("rst_irq", o_Irq, 0);

    // status after reset
    xfer(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, rd, err);
    chk("t1_status", rd, 8'h05);
    chk("t1_slverr", err, 0);

    // TX streaming
    xfer(1'b1, 1'b1, 8'h01, 1'b0, 8'h00, rd, err);
    xfer(1'b1, 1'b0, 8'hA5, 1'b0, 8'h00, rd, err);
    xfer(1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, rd, err);
    @(negedge clk);
    chk("t2_txvalid", o_TxValid, 1);
    chk("t2_txdata", o_TxData, 8'hA5);
    drain();
    drain();
    xfer(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, rd, err);
    chk("t2_tx_empty", rd[0], 1);

    // TX overfill with transmitter disabled
    xfer(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, rd, err);
    for (int i = 0; i < 5; i++) begin
      xfer(1'b1, 1'b0, 8'h50 + 8'(i), 1'b0, 8'h00, rd, err);
      chk("t3_fill_err", err, (i == 4));
    end
    xfer(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, rd, err);
    chk("t3_tx_full", rd[1:0], 2'b10);
    check_outs();

    // RX overflow, drain and overflow clear
    xfer(1'b1, 1'b1, 8'h02, 1'b0, 8'h00, rd, err);
    for (int i = 0; i < 5; i++) rx_push(8'h10 + 8'(i));
    check_outs();
    chk("t4_irq_set", o_Irq, 1);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, rd, err);
      chk("t4_rx_byte", rd, 8'h10 + 8'(i));
    end
    xfer(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, rd, err);
    chk("t4_ovf_seen", rd[4], 1);
    check_outs();
    chk("t4_irq_clear", o_Irq, 0);

    // long-held access phase commits once
    xfer(1'b1, 1'b1, 8'h04, 1'b0, 8'h00, rd, err);
    @(negedge clk);
    i_Psel = 1'b1; i_Penable = 1'b0; i_Pwrite = 1'b1; i_Paddr = 1'b0; i_Pwdata = 8'h77;
    @(negedge clk);
    i_Penable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_pready", o_Pready, (i >= 1));
    end
    i_Psel = 1'b0; i_Penable = 1'b0;
    model_xfer(1'b1, 1'b0, 8'h77, 1'b0, 8'h00, erd, eerr);
    xfer(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, rd, err);
    chk("t5_status", rd, 8'h04);

    // flush with a same-cycle RX strobe
    xfer(1'b1, 1'b1, 8'h04, 1'b0, 8'h00, rd, err);
    xfer(1'b1, 1'b1, 8'h03, 1'b0, 8'h00, rd, err);
    xfer(1'b1, 1'b0, 8'h21, 1'b0, 8'h00, rd, err);
    xfer(1'b1, 1'b0, 8'h22, 1'b0, 8'h00, rd, err);
    for (int i = 0; i < 3; i++) rx_push(8'h30 + 8'(i));
    xfer(1'b1, 1'b1, 8'h07, 1'b1, 8'hEE, rd, err);
    xfer(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, rd, err);
    chk("t6_status", rd, 8'h65);

    // reset during WAIT abandons the write
    @(negedge clk);
    i_Psel = 1'b1; i_Penable = 1'b0; i_Pwrite = 1'b1; i_Paddr = 1'b0; i_Pwdata = 8'h99;
    @(negedge clk);
    i_Penable = 1'b1;
    @(negedge clk);
    i_Presetn = 1'b0;
    @(negedge clk);
    i_Presetn = 1'b1; i_Psel = 1'b0; i_Penable = 1'b0;
    model_reset();
    chk("rst_wait_pready", o_Pready, 0);
    xfer(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, rd, err);
    chk("rst_wait_status", rd, 8'h05);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      logic [7:0] wd;
      logic       inj;
      logic [7:0] rb;
      wd  = 8'($urandom);
      inj = ($urandom_range(0, 3) == 0);
      rb  = 8'($urandom);
      case ($urandom_range(0, 5))
        0: xfer(1'b1, 1'b0, wd, inj, rb, rd, err);
        1: xfer(1'b0, 1'b0, wd, inj, rb, rd, err);
        2: xfer(1'b1, 1'b1, {5'b0, ($urandom_range(0, 7) == 0), 2'($urandom)}, inj, rb, rd, err);
        3: xfer(1'b0, 1'b1, wd, inj, rb, rd, err);
        4: rx_push(rb);
        default: drain();
      endcase
      check_outs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
